// File: rtl/activation_pkg.sv
// Shared Q1.15 activation constants and types.
//   Q15_W / Q15_FRAC : sample width and fractional bits
//   PROD_W           : signed product width for slope multiply
//   Q15_RND          : round-half-up constant added before the >>> Q15_FRAC
//   LRELU_SLOPE_DEF  : default leaky-ReLU negative slope, 0.1 in Q1.15
package activation_pkg;
  localparam int Q15_W    = 16;
  localparam int Q15_FRAC = 15;
  localparam int PROD_W   = 32;

  localparam logic signed [PROD_W-1:0] Q15_RND         = 32'sd16384;
  localparam logic signed [Q15_W-1:0]  LRELU_SLOPE_DEF = 16'sd3277;

  // One pipeline stage payload: sample, its sign and the frame marker.
  typedef struct packed {
    logic signed [Q15_W-1:0] data;
    logic                    neg;
    logic                    last;
  } lrelu_stage_t;
endpackage

// File: rtl/leaky_relu_core_q15.sv
// Combinational leaky-ReLU kernel in Q1.15.
//   x : signed Q1.15 input sample
//   y : x when x >= 0, else round(x * SLOPE_Q15 / 2^15) (round half up)
// SLOPE_Q15 must lie in 0..32767, so |y| <= |x| and no saturation is needed.
module leaky_relu_core_q15
  import activation_pkg::*;
#(
  parameter logic signed [Q15_W-1:0] SLOPE_Q15 = LRELU_SLOPE_DEF
) (
  input  logic signed [Q15_W-1:0] x,
  output logic signed [Q15_W-1:0] y
);
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sum;
  logic                     unused_sum_bits;

  assign prod = PROD_W'(x) * PROD_W'(SLOPE_Q15);
  assign sum  = prod + Q15_RND;
  // sum[30:15] is (sum >>> 15) truncated to 16 bits.
  assign y    = x[Q15_W-1] ? sum[Q15_FRAC +: Q15_W] : x;

  assign unused_sum_bits = ^{sum[PROD_W-1], sum[Q15_FRAC-1:0]};
endmodule

// File: rtl/leaky_relu_stream_q15.sv
// Streaming leaky-ReLU, Q1.15, valid/ready on both sides, 2-stage pipeline.
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready/s_data/s_last : upstream stream
//   m_valid/m_ready/m_data/m_last : downstream stream
//   sample_cnt            : samples accepted since the last accepted s_last
//   frame_cnt             : frames completed on the output (m_last transfers)
//   neg_cnt               : negative samples emitted (only with LRELU_STATS_EN)
// Optional feature macro: LRELU_STATS_EN adds the neg_cnt port and counter.
// S1 registers the raw sample and sign, S2 registers the kernel result.
module leaky_relu_stream_q15
  import activation_pkg::*;
#(
  parameter logic signed [Q15_W-1:0] SLOPE_Q15 = LRELU_SLOPE_DEF,
  parameter int                      CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [Q15_W-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [Q15_W-1:0] m_data,
  output logic                    m_last,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        frame_cnt
`ifdef LRELU_STATS_EN
  ,
  output logic [CNT_W-1:0]        neg_cnt
`endif
);
  localparam int STAGES = 2;

  logic [STAGES:1]         vld_pipe;
  lrelu_stage_t            s1_q, s2_q;
  logic                    run;     // low until the first edge after reset
  logic                    adv;     // S1 may move into S2 this cycle
  logic                    s_fire, m_fire;
  logic signed [Q15_W-1:0] core_y;

  leaky_relu_core_q15 #(.SLOPE_Q15(SLOPE_Q15)) u_core (
    .x (s1_q.data),
    .y (core_y)
  );

  assign adv     = !vld_pipe[2] || m_ready;
  assign s_ready = run && (!vld_pipe[1] || adv);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = vld_pipe[2] && m_ready;

  assign m_valid = vld_pipe[2];
  assign m_data  = s2_q.data;
  assign m_last  = s2_q.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      run <= 1'b1;
      // S2 only changes when empty or draining, so it holds under backpressure.
      if (adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1])
          s2_q <= '{data: core_y, neg: s1_q.neg, last: s1_q.last};
      end
      if (s_ready) begin
        vld_pipe[1] <= s_valid;
        if (s_valid)
          s1_q <= '{data: s_data, neg: s_data[Q15_W-1], last: s_last};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
    end else begin
      if (s_fire)
        sample_cnt <= s_last ? '0 : sample_cnt + CNT_W'(1);
      if (m_fire && s2_q.last)
        frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef LRELU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      neg_cnt <= '0;
    else if (m_fire && s2_q.neg)
      neg_cnt <= neg_cnt + CNT_W'(1);
  end
`else
  // Sign is carried through S2 only for the stats counter.
  logic unused_s2_neg;
  assign unused_s2_neg = s2_q.neg;
`endif
endmodule

// File: tb/tb_leaky_relu_stream_q15.sv
module tb_leaky_relu_stream_q15;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_data;
  logic [15:0] sample_cnt, frame_cnt;
`ifdef LRELU_STATS_EN
  logic [15:0] neg_cnt;
`endif

  leaky_relu_stream_q15 dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sample_cnt(sample_cnt), .frame_cnt(frame_cnt)
`ifdef LRELU_STATS_EN
    , .neg_cnt(neg_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference: leaky ReLU with slope 0.1 (3277/32768), rounded half up.
  function automatic logic [15:0] lrelu_model(input logic [15:0] x);
    int  xi;
    real r;
    xi = int'($signed(x));
    if (xi >= 0) return x;
    r = $floor(real'(xi) * 3277.0 / 32768.0 + 0.5);
    return 16'($rtoi(r));
  endfunction

  typedef struct packed { logic [15:0] y; logic last; logic neg; } exp_t;
  exp_t        q[$];
  logic [15:0] m_samp, m_frame, m_neg;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  // Scoreboard: at each negedge compare state, then account for the
  // transfers that the coming posedge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_samp = '0; m_frame = '0; m_neg = '0; prev_stall = 1'b0;
      chk1("rst_s_ready", s_ready, 1'b0);
      chk1("rst_m_valid", m_valid, 1'b0);
      chk16("rst_m_data", m_data, 16'h0);
      chk1("rst_m_last", m_last, 1'b0);
      chk16("rst_sample_cnt", sample_cnt, 16'h0);
      chk16("rst_frame_cnt", frame_cnt, 16'h0);
    end else begin
      chk16("sample_cnt", sample_cnt, m_samp);
      chk16("frame_cnt", frame_cnt, m_frame);
`ifdef LRELU_STATS_EN
      chk16("neg_cnt", neg_cnt, m_neg);
`endif
      if (prev_stall) begin
        chk1("stall_m_valid", m_valid, 1'b1);
        chk16("stall_m_data", m_data, prev_data);
        chk1("stall_m_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk1("spurious_m_valid", m_valid, 1'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk16("m_data", m_data, e.y);
          chk1("m_last", m_last, e.last);
          if (e.last) m_frame = m_frame + 16'd1;
          if (e.neg) m_neg = m_neg + 16'd1;
        end
      end
      if (s_valid && s_ready) begin
        q.push_back('{y: lrelu_model(s_data), last: s_last, neg: s_data[15]});
        m_samp = s_last ? 16'd0 : m_samp + 16'd1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk1("s_ready_after_release", s_ready, 1'b1);
  endtask

  // One isolated sample with m_ready=1; checks 2-cycle latency and value.
  task automatic send_one(input string name, input logic [15:0] x, input logic [15:0] y);
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = x; s_last = 1'b0;
    chk1({name, "_s_ready"}, s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    @(negedge clk); chk1({name, "_lat1"}, m_valid, 1'b0);
    @(negedge clk); chk1({name, "_lat2"}, m_valid, 1'b1);
    chk16({name, "_data"}, m_data, y);
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    s_valid = 1'b0; m_ready = 1'b1; n = 0;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    chk1({name, "_drained"}, q.size() == 0, 1'b1);
  endtask

  initial begin
    logic [15:0] vals [8];
    int acc, first_i, cnt_v, last_i, lastflag_i;
    logic fire;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    // Pin the model with hand-computed values.
    chk16("model_m8192", lrelu_model(16'hE000), 16'hFCCD);
    chk16("model_m32768", lrelu_model(16'h8000), 16'hF333);
    chk16("model_m1", lrelu_model(16'hFFFF), 16'h0000);
    chk16("model_m100", lrelu_model(16'hFF9C), 16'hFFF6);
    chk16("model_pos", lrelu_model(16'h7FFF), 16'h7FFF);
    do_reset();

    send_one("p0", 16'h0000, 16'h0000);
    send_one("p2000", 16'h2000, 16'h2000);
    send_one("p7fff", 16'h7FFF, 16'h7FFF);
    send_one("n8192", 16'hE000, 16'hFCCD);
    send_one("n16384", 16'hC000, 16'hF99A);
    send_one("n32768", 16'h8000, 16'hF333);

    // Back-to-back 8-sample frame.
    do_reset();
    m_ready = 1'b1; first_i = -1; cnt_v = 0; last_i = -1; lastflag_i = -1;
    for (int i = 0; i < 12; i++) begin
      s_valid = (i < 8); s_data = 16'(i * 1000 - 3000); s_last = (i == 7);
      @(negedge clk);
      if (m_valid) begin
        if (first_i < 0) first_i = i;
        cnt_v++; last_i = i;
        if (m_last) lastflag_i = i;
      end
      tick();
    end
    s_valid = 1'b0;
    chk16("frame_out_count", 16'(cnt_v), 16'd8);
    chk16("frame_first_out", 16'(first_i), 16'd2);
    chk16("frame_contig", 16'(last_i - first_i + 1), 16'd8);
    chk16("frame_m_last_pos", 16'(lastflag_i), 16'd9);
    chk16("frame_cnt_1", frame_cnt, 16'd1);
    chk16("sample_cnt_0", sample_cnt, 16'd0);

    // Backpressure: m_ready low for 5 cycles.
    for (int i = 0; i < 8; i++) vals[i] = 16'(i * 4099 - 16000);
    m_ready = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_data = vals[acc]; s_last = (acc == 7);
      @(negedge clk); fire = s_ready;
      tick();
      if (fire) acc++;
    end
    chk16("stall_accepted", 16'(acc), 16'd2);
    chk1("stall_s_ready_low", s_ready, 1'b0);
    m_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      s_valid = 1'b1; s_data = vals[acc]; s_last = (acc == 7);
      @(negedge clk); fire = s_ready;
      tick();
      if (fire) acc++;
    end
    chk16("stall_all_sent", 16'(acc), 16'd8);
    drain("stall");

    // Reset with 2 samples in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b0; tick(); end
    s_valid = 1'b0;
    chk1("inflight_m_valid", m_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk1("async_rst_m_valid", m_valid, 1'b0);
    chk16("async_rst_sample_cnt", sample_cnt, 16'd0);
    tick(); rst_n = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); chk1("no_stale_out", m_valid, 1'b0);
    end
    tick();

`ifdef LRELU_STATS_EN
    do_reset();
    m_ready = 1'b1;
    vals[0] = 16'hFFFF; vals[1] = 16'd5; vals[2] = 16'hFF9C; vals[3] = 16'd0;
    for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = vals[i]; s_last = 1'b0; tick(); end
    drain("neg");
    tick();
    chk16("neg_cnt_2", neg_cnt, 16'd2);
`endif

    // Randomized traffic with random backpressure.
    fire = 1'b0; s_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!s_valid || fire) begin
        s_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: s_data = 16'h8000;
          1: s_data = 16'h7FFF;
          2: s_data = 16'hFFFF;
          default: s_data = 16'($urandom);
        endcase
        s_last = ($urandom_range(0, 7) == 0);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if (c == 300) begin rst_n = 1'b0; #1; end
      if (c == 302) rst_n = 1'b1;
      @(negedge clk); fire = s_valid && s_ready;
      tick();
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/leaky_relu_stream_q15.md
LEAKY_RELU_STREAM_Q15 -- requirements
Module: leaky_relu_stream_q15

Interface
REQ-001 SHALL have parameter SLOPE_Q15, default 16'sd3277 (0.1 in Q1.15), the negative-side slope, constrained to 0..32767.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the sample/frame counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, 16, signed Q1.15), s_last (input, 1) as the upstream stream.
REQ-006 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, 16, signed Q1.15), m_last (output, 1) as the downstream stream.
REQ-007 SHALL have port sample_cnt, output, CNT_W, the samples accepted since the last frame end.
REQ-008 SHALL have port frame_cnt, output, CNT_W, the completed output frames.
REQ-009 SHALL have port neg_cnt, output, CNT_W, the negative samples emitted; this port exists only when LRELU_STATS_EN is defined.

Function
REQ-010 SHALL apply y = x for x >= 0, else y = round(x*SLOPE_Q15 / 2^15).
REQ-011 SHALL compute the negative-side product at 32-bit signed width, add 2^14, arithmetic-shift right 15 and keep the low 16 bits; no saturation is needed given REQ-001.
REQ-012 SHALL be a two-stage pipeline (S1: register input and sign, S2: register result), so latency is 2 cycles from s handshake to m_valid with no stalls.
REQ-013 SHALL transfer on a port only in a cycle where valid and ready are both high.
REQ-014 SHALL drive s_ready = !S1_valid || S1 advancing, and S1 advances when !S2_valid || m_ready, giving full throughput of 1 sample/cycle.
REQ-015 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0; m_valid SHALL NOT drop without a transfer.
REQ-016 SHALL carry s_last alongside its sample through both stages unchanged.
REQ-017 SHALL increment sample_cnt on each upstream transfer; on a transfer with s_last=1, sample_cnt SHALL become 0.
REQ-018 SHALL increment frame_cnt on each downstream transfer with m_last=1.
REQ-019 SHALL wrap all counters modulo 2^CNT_W silently.
REQ-020 SHALL, when accept and emit occur in the same cycle with both pipeline stages full, move data with no bubble and no loss.
REQ-021 SHALL produce the same result for x = -32768 as REQ-011, which is -3277 at the default slope.

Reset
REQ-022 SHALL, while rst_n=0, force s_ready=0, m_valid=0, m_data=0, m_last=0, all counters=0 and both stage valids=0.
REQ-023 SHALL discard in-flight samples when reset asserts mid-stream; no output appears after release until new input.
REQ-024 SHALL raise s_ready in the first clock edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro LRELU_STATS_EN defined, include neg_cnt, which increments on each downstream transfer whose source sample was negative.
REQ-026 SHALL, without LRELU_STATS_EN, omit the neg_cnt port and its logic; datapath behaviour is identical either way.

Structure
REQ-027 SHALL place the Q15 type width (16), the Q15 fractional bits (15), the rounding constant (2^14) and the default slope 3277 in shared package activation_pkg.
REQ-028 SHALL use one sub-module, leaky_relu_core_q15, the combinational kernel per REQ-010/011, instantiated in S1->S2.

Verification
REQ-029 SHALL cover: single samples 0x0000, 0x2000, 0x7FFF, m_ready=1 -> outputs 0x0000, 0x2000, 0x7FFF, each 2 cycles after accept.
REQ-030 SHALL cover: inputs -8192, -16384, -32768 -> -819, -1638, -3277 (0xFCCD, 0xF99A, 0xF333).
REQ-031 SHALL cover: a back-to-back 8-sample frame with s_last on the 8th and m_ready=1 -> 8 outputs on consecutive cycles, m_last on the 8th, frame_cnt=1, sample_cnt=0.
REQ-032 SHALL cover: m_ready held 0 for 5 cycles during a stream -> s_ready=0 after 2 samples buffered, m_data stable, no sample lost or duplicated after release.
REQ-033 SHALL cover: rst_n pulsed low with 2 samples in flight -> m_valid=0, counters 0, no stale output after release.
REQ-034 SHALL cover, with LRELU_STATS_EN: stream {-1, 5, -100, 0} -> neg_cnt=2.
